// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, STOP_BITS stop bits; line idles high.
// Latency: x goes low one clk after accept; rdy is low for (9+STOP_BITS[+1 parity])*CLKS_PER_BIT cycles.
// Backpressure: en is ignored while rdy=0, except at the final stop edge, where a held en chains the next frame. Macro: UART_TX_PARITY_EN.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] data,
    output logic       x,
    output logic       rdy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be >= 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      idx, idx_nxt;
    logic [7:0]      sh, sh_nxt;
    logic            stop_idx, stop_nxt;
    logic            x_nxt, rdy_nxt;
    logic            bit_end, frame_end, accept;
`ifdef UART_TX_PARITY_EN
    logic            par, par_nxt;
`endif

    assign bit_end   = (cnt == CNT_MAX);
    assign frame_end = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
    // A held en at the last stop edge starts the next frame with no idle gap.
    assign accept    = en && ((state == IDLE) || frame_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            stop_idx <= 1'b0;
            x        <= 1'b1;
            rdy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            sh       <= sh_nxt;
            stop_idx <= stop_nxt;
            x        <= x_nxt;
            rdy      <= rdy_nxt;
`ifdef UART_TX_PARITY_EN
            par      <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        sh_nxt    = sh;
        stop_nxt  = stop_idx;
        x_nxt     = x;
        rdy_nxt   = rdy;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par;
`endif
        if (state != IDLE) begin
            cnt_nxt = bit_end ? '0 : cnt + CW'(1);
        end

        case (state)
            IDLE: ;
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    x_nxt     = sh[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_nxt  = {1'b0, sh[7:1]};
                    idx_nxt = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        x_nxt     = par;
`else
                        state_nxt = STOP;
                        x_nxt     = 1'b1;
                        stop_nxt  = 1'b0;
`endif
                    end else begin
                        x_nxt = sh[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    x_nxt     = 1'b1;
                    stop_nxt  = 1'b0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        state_nxt = IDLE;
                        rdy_nxt   = 1'b1;
                    end else begin
                        stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                x_nxt     = 1'b1;
                rdy_nxt   = 1'b1;
            end
        endcase

        if (accept) begin
            state_nxt = START;
            sh_nxt    = data;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            stop_nxt  = 1'b0;
            x_nxt     = 1'b0;
            rdy_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_nxt   = ^data;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, STOP_BITS=1; expected line bits derived from the byte under test.
module tb_uart_tx;
    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int FL  = (1 + 8 + PB + SB) * CPB;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic       x;
    logic       rdy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .data (data),
        .x    (x),
        .rdy  (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int pos;
        pos = k / CPB;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (PB == 1 && pos == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, {31'd0, rdy}, 32'd1);
    endtask

    // Entered at a negedge; the accept happens on the next posedge.
    task automatic frame(input logic [7:0] b, input int poke, input bit chain,
                         input logic [7:0] nb, input string tag);
        int low;
        low  = 0;
        data = b;
        en   = 1'b1;
        @(posedge clk);
        #1;
        if (chain) data = nb;
        else       en   = 1'b0;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            check($sformatf("%s_x%0d", tag, k), {31'd0, x}, {31'd0, frame_bit(b, k)});
            if (!rdy) low++;
            if (k == poke) begin
                en   = 1'b1;
                data = 8'hFF;
            end else if (k == poke + 1) begin
                en   = 1'b0;
                data = b;
            end
        end
        check({tag, "_rdy_low"}, low, FL);
        if (!chain) begin
            @(negedge clk);
            check({tag, "_rdy_end"}, {31'd0, rdy}, 32'd1);
            check({tag, "_x_end"}, {31'd0, x}, 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        data  = 8'h00;
        repeat (3) begin
            @(negedge clk);
            check("rst_x", {31'd0, x}, 32'd1);
            check("rst_rdy", {31'd0, rdy}, 32'd1);
        end
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_x", {31'd0, x}, 32'd1);
        check("post_rst_rdy", {31'd0, rdy}, 32'd1);

        wait_idle("a5");
        frame(8'hA5, -1, 1'b0, 8'h00, "a5");

        wait_idle("3c");
        frame(8'h3C, 10, 1'b0, 8'h00, "3c");

        wait_idle("b2b");
        frame(8'h01, -1, 1'b1, 8'h80, "b2b_01");
        frame(8'h80, -1, 1'b0, 8'h00, "b2b_80");

        wait_idle("07");
        frame(8'h07, -1, 1'b0, 8'h00, "07");

        // Abort 8'h00 during data bit 3 (frame cycles 16..19).
        wait_idle("mid");
        data = 8'h00;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (18) @(negedge clk);
        check("mid_x_before", {31'd0, x}, 32'd0);
        check("mid_rdy_before", {31'd0, rdy}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_x", {31'd0, x}, 32'd1);
        check("mid_rst_rdy", {31'd0, rdy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wait_idle("55");
        frame(8'h55, -1, 1'b0, 8'h00, "55");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
